// File: rtl/encoder_8b10b.sv
// 8b/10b encoder with a single valid/ready output register stage.
// Define ENCODER_8B10B_KCHAR_EN to enable K-character encoding and code_err reporting.
module encoder_8b10b #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] data_in,
    input  logic       k_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] data_out,
    output logic       rd_out,
    output logic       code_err
);

    // 5b/6b codes in the RD- column, written abcdei (a is the MSB of the literal)
    function automatic logic [5:0] d6_rdm(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;  5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;  5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;  5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;  5'd19: c = 6'b110010;  5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;  5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;  default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b codes (fghj) used when the RD entering the 4b sub-block is negative
    function automatic logic [3:0] d4_rdm(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;  default: c = 4'b1110;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] k4_rdm(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0: c = 4'b1011;  3'd1: c = 4'b0110;  3'd2: c = 4'b1010;  3'd3: c = 4'b1100;
            3'd4: c = 4'b1101;  3'd5: c = 4'b0101;  3'd6: c = 4'b1001;  default: c = 4'b0111;
        endcase
        return c;
    endfunction

    logic [4:0] x;
    logic [2:0] y;
    logic       is_k28, is_kx7, k_bad;

    assign x = data_in[4:0];
    assign y = data_in[7:5];

`ifdef ENCODER_8B10B_KCHAR_EN
    assign is_k28 = k_in && (x == 5'd28);
    assign is_kx7 = k_in && (y == 3'd7) &&
                    ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30));
    assign k_bad  = k_in && !is_k28 && !is_kx7;
`else
    logic unused_k_in;
    assign unused_k_in = k_in;
    assign is_k28      = 1'b0;
    assign is_kx7      = 1'b0;
    assign k_bad       = 1'b0;
`endif

    logic       rd_q, rd_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [9:0] data_q, data_d;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       unbal6, unbal4, rd6, rd_nxt, use_alt, flip4, accept;

    always_comb begin
        c6     = is_k28 ? 6'b001111 : d6_rdm(x);
        unbal6 = ($countones(c6) != 3);
        // D.7 is balanced but still has distinct RD+/RD- forms
        if (rd_q && (unbal6 || x == 5'd7)) begin
            c6 = ~c6;
        end
        rd6 = rd_q ^ unbal6;

        use_alt = (y == 3'd7) &&
                  ((!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                   ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        if (is_k28) begin
            c4 = k4_rdm(y);
        end else if (is_kx7 || use_alt) begin
            c4 = 4'b0111;
        end else begin
            c4 = d4_rdm(y);
        end
        unbal4 = ($countones(c4) != 2);
        flip4  = is_k28 || is_kx7 || unbal4 || (y == 3'd3);
        if (rd6 && flip4) begin
            c4 = ~c4;
        end
        rd_nxt = rd6 ^ unbal4;
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        rd_d    = rd_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
            rd_d    = rd_nxt;
            err_d   = k_bad;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 10'h000;
            rd_q    <= RD_INIT;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign data_out  = data_q;
    assign rd_out    = rd_q;
    assign code_err  = err_q;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Scoreboard bench for encoder_8b10b: table-driven reference model, random and directed stimulus.
module tb_encoder_8b10b;

    logic       clk, rst, in_valid, in_ready, k_in, out_valid, out_ready, rd_out, code_err;
    logic [7:0] data_in;
    logic [9:0] data_out;

    encoder_8b10b #(.RD_INIT(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .k_in     (k_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .rd_out   (rd_out),
        .code_err (code_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [9:0] sym;
        logic       rd;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic mrd    = 1'b0;
    logic exp_valid = 1'b0;

    // Published tables, both RD columns written out (abcdei / fghj, first bit is MSB)
    logic [5:0] t6m [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
        6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
        6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
        6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
        6'b011110, 6'b101011};
    logic [5:0] t6p [32] = '{6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001,
        6'b011001, 6'b000111, 6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
        6'b011100, 6'b101000, 6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
        6'b011010, 6'b000101, 6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001,
        6'b100001, 6'b010100};
    logic [3:0] t4m [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
    logic [3:0] k4m [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
    logic [7:0] kbytes [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE};

    // Disparity of a sub-block: more ones -> RD+, more zeros -> RD-, balanced keeps RD
    function automatic logic rd_after(input int ones, input int half, input logic rd);
        if (ones > half) return 1'b1;
        if (ones < half) return 1'b0;
        return rd;
    endfunction

    function automatic void model(input logic [7:0] b, input logic k, input logic rd,
                                  output logic [9:0] sym, output logic rd_o, output logic err);
        int         x, y;
        logic       kv, r6, alt;
        logic [5:0] c6;
        logic [3:0] c4;
        x  = int'(b[4:0]);
        y  = int'(b[7:5]);
        kv = 1'b0;
`ifdef ENCODER_8B10B_KCHAR_EN
        foreach (kbytes[i]) if (k && b == kbytes[i]) kv = 1'b1;
        err = k && !kv;
`else
        err = 1'b0;
`endif
        if (kv && x == 28) c6 = rd ? 6'b110000 : 6'b001111;
        else               c6 = rd ? t6p[x] : t6m[x];
        r6  = rd_after($countones(c6), 3, rd);
        alt = (y == 7) && ((!r6 && (x == 17 || x == 18 || x == 20)) ||
                           (r6 && (x == 11 || x == 13 || x == 14)));
        if (kv && x == 28)  c4 = r6 ? k4p[y] : k4m[y];
        else if (kv || alt) c4 = r6 ? 4'b1000 : 4'b0111;
        else                c4 = r6 ? t4p[y] : t4m[y];
        rd_o = rd_after($countones(c4), 2, r6);
        for (int i = 0; i < 6; i++) sym[i] = c6[5-i];
        for (int i = 0; i < 4; i++) sym[6+i] = c4[3-i];
    endfunction

    function automatic exp_t mk(input logic [9:0] s, input logic r, input logic e);
        exp_t t;
        t.sym = s;
        t.rd  = r;
        t.err = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; inputs change on the falling edge, acceptance is decided by the
    // bench's own flow-control model just before the rising edge.
    task automatic cyc(input logic iv, input logic [7:0] d, input logic k, input logic ordy,
                       input logic ov, input exp_t oexp);
        logic       acc, r, er;
        logic [9:0] s;
        @(negedge clk);
        in_valid  = iv;
        data_in   = d;
        k_in      = k;
        out_ready = ordy;
        #4;
        acc = iv && (!exp_valid || ordy);
        if (acc) begin
            model(d, k, mrd, s, r, er);
            mrd = r;
            q.push_back(ov ? oexp : mk(s, r, er));
        end
        exp_valid = acc || (exp_valid && !ordy);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " data_out"},  32'(data_out),  32'd0);
        chk({tag, " rd_out"},    32'(rd_out),    32'd0);
        chk({tag, " code_err"},  32'(code_err),  32'd0);
        chk({tag, " in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Monitor: checks the presented symbol every cycle and retires it on out_ready
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
                chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
                if (q.size() != 0) begin
                    e = q[0];
                    chk("data_out", 32'(data_out), 32'(e.sym));
                    chk("rd_out", 32'(rd_out), 32'(e.rd));
                    chk("code_err", 32'(code_err), 32'(e.err));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    localparam logic KEN =
`ifdef ENCODER_8B10B_KCHAR_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        exp_t nx;
        logic [7:0] b;
        logic       k;
        nx        = mk(10'h0, 1'b0, 1'b0);
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = 8'h00;
        k_in      = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        chk("in_ready in reset", 32'(in_ready), 32'd1);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", 32'(in_ready), 32'd1);

        cyc(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, mk(10'h0B9, 1'b0, 1'b0));
        cyc(1'b1, 8'hBC, 1'b1, 1'b1, 1'b1, KEN ? mk(10'h17C, 1'b1, 1'b0) : mk(10'h15C, 1'b0, 1'b0));
        cyc(1'b1, 8'hBC, 1'b1, 1'b1, 1'b1, KEN ? mk(10'h283, 1'b0, 1'b0) : mk(10'h15C, 1'b0, 1'b0));
        cyc(1'b1, 8'hF1, 1'b0, 1'b1, 1'b1, mk(10'h3B1, 1'b1, 1'b0));
        cyc(1'b1, 8'h60, 1'b0, 1'b1, 1'b0, nx);
        cyc(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, mk(10'h0B9, 1'b0, KEN));
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, nx);

        // Backpressure: symbol held for 5 cycles, next byte encoded from the held RD
        cyc(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, nx);
        repeat (5) cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, nx);
        cyc(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, nx);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, nx);

        // Reset while a symbol is stalled
        cyc(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, nx);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid reset");
        q.delete();
        mrd       = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, mk(10'h0B9, 1'b0, 1'b0));

        for (int i = 0; i < 3000; i++) begin
            k = ($urandom_range(0, 3) == 0);
            b = 8'($urandom);
            if (k && $urandom_range(0, 1) == 1) b = kbytes[$urandom_range(0, 11)];
            cyc($urandom_range(0, 9) < 7, b, k, $urandom_range(0, 9) < 7, 1'b0, nx);
        end

        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, nx);
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
